// File: rtl/grf_sb.sv
// grf_sb: register file with write bypass and a per-register pending-write scoreboard
module grf_sb #(
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int CNT_W  = 2,
    parameter int BYPASS = 1,
    parameter int LOG    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    a1,
    input  logic [AW-1:0]    a2,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic             busy1,
    output logic             busy2,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_a,
    output logic             iss_rdy,
    input  logic             we,
    input  logic [AW-1:0]    a3,
    input  logic [WIDTH-1:0] wd,
    input  logic [31:0]      pc,
    output logic             wb_err
);
    localparam int N = 1 << AW;
    localparam logic [CNT_W-1:0] CMAX = '1;
    logic [WIDTH-1:0] mem [N];
    logic [CNT_W-1:0] cnt [N];
    logic fwd1, fwd2, acc, wb, both;
    always_comb begin
        fwd1    = BYPASS != 0 && we && a3 == a1;
        fwd2    = BYPASS != 0 && we && a3 == a2;
        r1      = a1 == '0 ? '0 : fwd1 ? wd : mem[a1];
        r2      = a2 == '0 ? '0 : fwd2 ? wd : mem[a2];
        busy1   = a1 != '0 && cnt[a1] != '0 && !(fwd1 && cnt[a1] == CNT_W'(1));
        busy2   = a2 != '0 && cnt[a2] != '0 && !(fwd2 && cnt[a2] == CNT_W'(1));
        iss_rdy = iss_a == '0 || cnt[iss_a] != CMAX;
        acc     = iss_en && iss_rdy && iss_a != '0;
        wb      = we && a3 != '0;
        both    = acc && wb && iss_a == a3;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
                cnt[i] <= '0;
            end
            wb_err <= 1'b0;
        end else begin
            if (wb) mem[a3] <= wd;
            if (acc && !both) cnt[iss_a] <= cnt[iss_a] + CNT_W'(1);
            if (wb && !both && cnt[a3] != '0) cnt[a3] <= cnt[a3] - CNT_W'(1);
            if (wb && !both && cnt[a3] == '0) wb_err <= 1'b1;
            if (LOG != 0 && we) $display("@%h: $%d <= %h", pc, a3, wd);
        end
    end
endmodule

// File: tb/tb_grf_sb.sv
// tb_grf_sb: randomized and directed checks of grf_sb against an array-based reference model
module tb_grf_sb;
    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  a1 = '0, a2 = '0, iss_a = '0, a3 = '0;
    logic [31:0] r1, r2, wd = '0, pc = '0;
    logic        busy1, busy2, iss_en = 1'b0, iss_rdy, we = 1'b0, wb_err;
    int total = 0, bad = 0;
    logic [31:0] m_mem [32];
    int          m_cnt [32];
    logic        m_err;

    grf_sb dut (.clk(clk), .rst(rst), .a1(a1), .a2(a2), .r1(r1), .r2(r2),
                .busy1(busy1), .busy2(busy2), .iss_en(iss_en), .iss_a(iss_a),
                .iss_rdy(iss_rdy), .we(we), .a3(a3), .wd(wd), .pc(pc), .wb_err(wb_err));

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_r(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we && a3 == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        int pending;
        if (a == 0) return 1'b0;
        pending = m_cnt[a];
        if (we && a3 == a && pending > 0) pending = pending - 1;
        return pending != 0;
    endfunction

    function automatic logic exp_rdy();
        return iss_a == 0 || m_cnt[iss_a] < 3;
    endfunction

    function automatic void mdl_update();
        logic acc, inc, dec;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r] = '0;
                m_cnt[r] = 0;
            end
            m_err = 1'b0;
            return;
        end
        acc = iss_en && exp_rdy();
        if (we && a3 != 0) m_mem[a3] = wd;
        for (int r = 1; r < 32; r++) begin
            inc = acc && iss_a == r;
            dec = we && a3 == r;
            if (inc && !dec) m_cnt[r]++;
            else if (dec && !inc) begin
                if (m_cnt[r] > 0) m_cnt[r]--;
                else m_err = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        mdl_update();
        #1;
    endtask

    task automatic idle();
        iss_en = 1'b0; we = 1'b0; iss_a = '0; a3 = '0; wd = '0; pc = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(); tick();
        a1 = 5'd3; a2 = 5'd0; iss_a = 5'd5; #2;
        total++; if (r1 !== 32'h0) begin bad++; $display("FAIL reset_r1 got=%h exp=0", r1); end
        total++; if (r2 !== 32'h0) begin bad++; $display("FAIL reset_r2 got=%h exp=0", r2); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        total++; if (iss_rdy !== 1'b1) begin bad++; $display("FAIL reset_iss_rdy got=%b exp=1", iss_rdy); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
    endtask

    task automatic test_basic();
        do_reset();
        iss_en = 1'b1; iss_a = 5'd5; we = 1'b1; a3 = 5'd5; wd = 32'h12345678; pc = 32'h3000;
        tick(); idle();
        a1 = 5'd5; #2;
        total++; if (r1 !== 32'h12345678) begin bad++; $display("FAIL basic_r1 got=%h exp=12345678", r1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL basic_busy1 got=%b exp=0", busy1); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL basic_wb_err got=%b exp=0", wb_err); end
    endtask

    task automatic test_r0();
        do_reset();
        we = 1'b1; a3 = 5'd0; wd = 32'hFFFFFFFF; pc = 32'h3004;
        tick(); idle();
        a2 = 5'd0; #2;
        total++; if (r2 !== 32'h0) begin bad++; $display("FAIL r0_read got=%h exp=0", r2); end
        iss_en = 1'b1; iss_a = 5'd0; #2;
        total++; if (iss_rdy !== 1'b1) begin bad++; $display("FAIL r0_iss_rdy got=%b exp=1", iss_rdy); end
        tick(); idle(); #2;
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL r0_busy2 got=%b exp=0", busy2); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL r0_wb_err got=%b exp=0", wb_err); end
    endtask

    task automatic test_bypass();
        do_reset();
        iss_en = 1'b1; iss_a = 5'd7; tick(); tick(); idle();
        we = 1'b1; a3 = 5'd7; wd = 32'h1; tick();
        a1 = 5'd7; wd = 32'h2; #2;
        total++; if (r1 !== 32'h2) begin bad++; $display("FAIL bypass_r1 got=%h exp=2", r1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL bypass_busy1 got=%b exp=0", busy1); end
        we = 1'b0; #1;
        total++; if (r1 !== 32'h1) begin bad++; $display("FAIL bypass_old got=%h exp=1", r1); end
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL bypass_busy_nowe got=%b exp=1", busy1); end
        we = 1'b1; tick(); idle(); #2;
        total++; if (r1 !== 32'h2) begin bad++; $display("FAIL bypass_next got=%h exp=2", r1); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL bypass_wb_err got=%b exp=0", wb_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        iss_en = 1'b1; iss_a = 5'd9;
        tick(); tick(); tick();
        a1 = 5'd9; #2;
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sat_busy1 got=%b exp=1", busy1); end
        total++; if (iss_rdy !== 1'b0) begin bad++; $display("FAIL sat_iss_rdy got=%b exp=0", iss_rdy); end
        tick();
        iss_en = 1'b0; we = 1'b1; a3 = 5'd9; tick();
        iss_en = 1'b1; #2;
        total++; if (iss_rdy !== 1'b1) begin bad++; $display("FAIL sat_rdy_after_wb got=%b exp=1", iss_rdy); end
        tick();
        iss_en = 1'b0; tick(); #2;
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL sat_final_bypass got=%b exp=0", busy1); end
        tick(); idle(); #2;
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL sat_drained got=%b exp=0", busy1); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL sat_wb_err got=%b exp=0", wb_err); end
    endtask

    task automatic test_error_reset();
        do_reset();
        we = 1'b1; a3 = 5'd4; wd = 32'hAA; tick(); idle(); #2;
        total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", wb_err); end
        tick(); #2;
        total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", wb_err); end
        rst = 1'b1; we = 1'b1; a3 = 5'd4; wd = 32'h55; tick();
        rst = 1'b0; idle(); a1 = 5'd4; #2;
        total++; if (r1 !== 32'h0) begin bad++; $display("FAIL err_rst_mem got=%h exp=0", r1); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL err_rst_flag got=%b exp=0", wb_err); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst    = $urandom_range(0, 59) == 0;
            iss_en = $urandom_range(0, 1) == 1;
            iss_a  = 5'($urandom_range(0, 7));
            we     = $urandom_range(0, 2) == 0;
            a3     = 5'($urandom_range(0, 7));
            wd     = $urandom;
            pc     = 32'h4000 + 32'(n * 4);
            a1     = 5'($urandom_range(0, 7));
            a2     = $urandom_range(0, 3) == 0 ? a3 : 5'($urandom_range(0, 7));
            #2;
            total++; if (r1 !== exp_r(a1)) begin bad++; $display("FAIL rnd_r1 n=%0d got=%h exp=%h", n, r1, exp_r(a1)); end
            total++; if (r2 !== exp_r(a2)) begin bad++; $display("FAIL rnd_r2 n=%0d got=%h exp=%h", n, r2, exp_r(a2)); end
            total++; if (busy1 !== exp_busy(a1)) begin bad++; $display("FAIL rnd_busy1 n=%0d got=%b exp=%b", n, busy1, exp_busy(a1)); end
            total++; if (busy2 !== exp_busy(a2)) begin bad++; $display("FAIL rnd_busy2 n=%0d got=%b exp=%b", n, busy2, exp_busy(a2)); end
            total++; if (iss_rdy !== exp_rdy()) begin bad++; $display("FAIL rnd_iss_rdy n=%0d got=%b exp=%b", n, iss_rdy, exp_rdy()); end
            total++; if (wb_err !== m_err) begin bad++; $display("FAIL rnd_wb_err n=%0d got=%b exp=%b", n, wb_err, m_err); end
            tick();
        end
        rst = 1'b0; idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_r0();
        test_bypass();
        test_saturation();
        test_error_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
